// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: command/state encodings and I/O addresses shared with the cpu FSM
package mem_responder_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_ILL   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [8:0] ADDR_SW  = 9'h140;
    localparam logic [8:0] ADDR_LED = 9'h100;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side memory command/response bundle
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;

    modport master (output mem_cmd, mem_addr, din, input dout, rd_valid);
    modport slave  (input mem_cmd, mem_addr, din, output dout, rd_valid);
endinterface

// File: rtl/mem_responder_ram_sp.sv
// ram_sp: single-port RAM, synchronous write, registered read, array not reset
module ram_sp #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    // write and read share the port; rdata holds until the next enabled read
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-mapped RAM/switch/LED responder with sticky error flag
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int RAM_AW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    input  logic [7:0]            sw,
    output logic [7:0]            led,
    output logic                  err
);
    cmd_e              cmd;
    state_e            state;
    state_e            nxt;
    logic              hit_ram, hit_sw, hit_led;
    logic              rd, wr, bad;
    logic              from_ram;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] ram_q;

    // combinational address decode and next-state selection
    always_comb begin
        cmd     = cmd_e'(bus.mem_cmd);
        hit_ram = !bus.mem_addr[ADDR_W-1];
        hit_sw  = bus.mem_addr == ADDR_W'(ADDR_SW);
        hit_led = bus.mem_addr == ADDR_W'(ADDR_LED);
        rd      = cmd == CMD_READ;
        wr      = cmd == CMD_WRITE;
        bad     = (cmd == CMD_ILL) || (rd && !(hit_ram || hit_sw)) || (wr && !(hit_ram || hit_led));
        nxt     = bad ? ERR : rd ? RD : wr ? WR : IDLE;
    end

    ram_sp #(.DW(DATA_W), .AW(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (wr && hit_ram),
        .re    (rd && hit_ram),
        .addr  (bus.mem_addr[RAM_AW-1:0]),
        .wdata (bus.din),
        .rdata (ram_q)
    );

    // FSM plus registered LED, sticky error and read-source/data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            led      <= '0;
            err      <= 1'b0;
            dout_q   <= '0;
            from_ram <= 1'b0;
        end else begin
            state <= nxt;
            err   <= err | bad;
            if (wr && hit_led) led <= bus.din[7:0];
            if (rd) begin
                from_ram <= hit_ram;
                dout_q   <= hit_sw ? DATA_W'(sw) : '0;
            end
        end
    end

    assign bus.dout     = from_ram ? ram_q : dout_q;
    assign bus.rd_valid = state == RD;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard test of mem_responder
module tb_mem_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] led;
    logic       err;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] sb [$];

    mem_responder_if bus ();

    mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sw    (sw),
        .led   (led),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one command at negedge, let the DUT sample it, then check the response
    task automatic step(input string tag, input logic [1:0] c, input logic [8:0] a,
                        input logic [15:0] d, input logic push, input logic [15:0] exp);
        @(negedge clk);
        bus.mem_cmd  = c;
        bus.mem_addr = a;
        bus.din      = d;
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
        chk({tag, "_rv"}, {15'd0, bus.rd_valid}, {15'd0, push});
        if (bus.rd_valid && sb.size() != 0) chk({tag, "_dout"}, bus.dout, sb.pop_front());
    endtask

    initial begin
        bus.mem_cmd  = 2'b00;
        bus.mem_addr = '0;
        bus.din      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", bus.dout, 16'h0000);
        chk("rst_led", {8'h00, led}, 16'h0000);
        chk("rst_rv", {15'd0, bus.rd_valid}, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'h0000);

        // release reset with a write presented in the same cycle
        @(negedge clk);
        reset        = 1'b1;
        bus.mem_cmd  = 2'b01;
        bus.mem_addr = 9'h000;
        bus.din      = 16'hD105;
        #2;
        chk("pre_edge_rv", {15'd0, bus.rd_valid}, 16'h0000);
        chk("pre_edge_dout", bus.dout, 16'h0000);
        @(posedge clk);
        #1;
        step("rd0", 2'b10, 9'h000, 16'h0000, 1'b1, 16'hD105);

        step("wr23", 2'b01, 9'h023, 16'hBEEF, 1'b0, 16'h0000);
        step("rd23", 2'b10, 9'h023, 16'h0000, 1'b1, 16'hBEEF);
        chk("err_clean", {15'd0, err}, 16'h0000);

        sw = 8'h5A;
        step("rd_sw", 2'b10, 9'h140, 16'h0000, 1'b1, 16'h005A);
        step("wr_led", 2'b01, 9'h100, 16'h12C3, 1'b0, 16'h0000);
        chk("led", {8'h00, led}, 16'h00C3);
        step("rd0_again", 2'b10, 9'h000, 16'h0000, 1'b1, 16'hD105);

        // back-to-back reads, each with its own pulse
        sw = 8'hA7;
        step("b2b_a", 2'b10, 9'h023, 16'h0000, 1'b1, 16'hBEEF);
        step("b2b_b", 2'b10, 9'h140, 16'h0000, 1'b1, 16'h00A7);
        step("b2b_c", 2'b10, 9'h000, 16'h0000, 1'b1, 16'hD105);
        step("idle", 2'b00, 9'h000, 16'h0000, 1'b0, 16'h0000);

        step("rd_unmapped", 2'b10, 9'h1FF, 16'h0000, 1'b0, 16'h0000);
        chk("unmapped_dout", bus.dout, 16'h0000);
        chk("unmapped_err", {15'd0, err}, 16'h0001);
        step("rd_after_err", 2'b10, 9'h023, 16'h0000, 1'b1, 16'hBEEF);
        chk("err_sticky", {15'd0, err}, 16'h0001);

        step("wr10", 2'b01, 9'h010, 16'h1234, 1'b0, 16'h0000);
        step("illegal", 2'b11, 9'h010, 16'hFFFF, 1'b0, 16'h0000);
        chk("ill_err", {15'd0, err}, 16'h0001);
        chk("ill_dout", bus.dout, 16'hBEEF);
        chk("ill_led", {8'h00, led}, 16'h00C3);
        step("rd10", 2'b10, 9'h010, 16'h0000, 1'b1, 16'h1234);

        // reset asserted while a read is in flight
        @(negedge clk);
        bus.mem_cmd  = 2'b10;
        bus.mem_addr = 9'h023;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_rv", {15'd0, bus.rd_valid}, 16'h0000);
        chk("rst_mid_led", {8'h00, led}, 16'h0000);
        chk("rst_mid_err", {15'd0, err}, 16'h0000);
        chk("rst_mid_dout", bus.dout, 16'h0000);
        @(negedge clk);
        reset       = 1'b1;
        bus.mem_cmd = 2'b00;
        step("ram_kept", 2'b10, 9'h010, 16'h0000, 1'b1, 16'h1234);
        chk("err_after_rst", {15'd0, err}, 16'h0000);
        step("end_idle", 2'b00, 9'h000, 16'h0000, 1'b0, 16'h0000);
        chk("sb_empty", 16'(sb.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter ADDR_W, default 9, mem_addr width.
REQ-003 Parameter RAM_AW, default 8, RAM index width; the RAM holds 2^RAM_AW words.
REQ-004 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port mem_cmd, input, 2, command from the CPU: 2'b00 NONE, 2'b10 READ, 2'b01 WRITE, 2'b11 ILLEGAL.
REQ-007 Port mem_addr, input, ADDR_W, word address from the CPU.
REQ-008 Port din, input, DATA_W, write data (the CPU datapath output).
REQ-009 Port dout, output, DATA_W, read data returned to the CPU "in" port.
REQ-010 Port sw, input, 8, switch inputs, memory-mapped for reads.
REQ-011 Port led, output, 8, LED register, memory-mapped for writes.
REQ-012 Port rd_valid, output, 1, high for exactly one cycle when dout carries new read data.
REQ-013 Port err, output, 1, sticky error flag.

Function
REQ-014 The address map SHALL be as follows:
- mem_addr[8]==0: RAM word mem_addr[RAM_AW-1:0].
- 9'h140: SW port (read only).
- 9'h100: LED port (write only).
- All other addresses: unmapped.
REQ-015 A READ sampled at edge t SHALL place the data on dout after edge t, hold it until the next completed read, and raise rd_valid in cycle t+1 only (1-cycle latency).
REQ-016 A READ of RAM SHALL return the stored word; a READ of SW SHALL return {8'h00, sw} sampled at edge t; a READ of an unmapped address SHALL return 16'h0000 and set err.
REQ-017 A WRITE of RAM at edge t SHALL update the word at edge t; a READ of the same address at edge t+1 SHALL return the new value.
REQ-018 A WRITE of LED SHALL load led <= din[7:0]; a WRITE of SW or of an unmapped address SHALL change no storage and SHALL set err.
REQ-019 ILLEGAL mem_cmd SHALL set err and SHALL change no storage, dout or led.
REQ-020 NONE SHALL change nothing except state, which returns to IDLE.
REQ-021 The FSM SHALL have states IDLE, RD, WR and ERR:
- Next state is RD for READ, WR for WRITE, ERR for any erroring access or ILLEGAL, and IDLE for NONE.
- Transitions are evaluated every edge.
- rd_valid = (state==RD).
REQ-022 Back-to-back READs SHALL each produce one rd_valid pulse with per-command data.
REQ-023 err SHALL remain high once set, until reset.

Reset
REQ-024 While reset is low, regardless of clk, all of the following SHALL hold:
- dout = 16'h0000, led = 8'h00, rd_valid = 0, err = 0, state = IDLE.
REQ-025 RAM contents SHALL NOT be cleared by reset.
REQ-026 A command presented in the same cycle as reset deassertion SHALL be sampled at the first rising edge after deassertion.
REQ-027 Reset asserted mid-read SHALL suppress the pending rd_valid.

Structure
REQ-028 The mem_cmd encodings, the FSM state encodings, and the addresses 9'h140 and 9'h100 SHALL live in a shared package, also used by the cpu FSM.
REQ-029 Storage SHALL be one sub-module, ram_sp: single-port, synchronous write, registered read, with no reset on the array.
REQ-030 Address decode SHALL be combinational; led, dout, err and state SHALL be registered.

Verification
REQ-031 Reset release, then READ 9'h000 -> dout=16'h0000 with rd_valid low until edge 1; after reset and a preload of RAM[0]=16'hD105, READ 9'h000 -> dout=16'hD105 and a rd_valid pulse one cycle later.
REQ-032 WRITE 9'h023 din=16'hBEEF, then READ 9'h023 on the next cycle -> dout=16'hBEEF, rd_valid one cycle later, err=0.
REQ-033 sw=8'h5A, READ 9'h140 -> dout=16'h005A; WRITE 9'h100 din=16'h12C3 -> led=8'hC3 and RAM unchanged.
REQ-034 READ 9'h1FF -> dout=16'h0000 and err=1; err stays 1 through subsequent valid accesses until reset.
REQ-035 mem_cmd=2'b11 at 9'h010 -> err=1 and RAM[0x10], dout and led unchanged; then reset low mid-READ -> rd_valid stays 0 and led=8'h00.
